// File: rtl/demux_rr_sched_pkg.sv
// demux_rr_sched shared types: FSM states, channel constants
// and the reference next-enabled-channel search.
package demux_sched_pkg;

   localparam int NCH   = 8;
   localparam int SEL_W = 3;

   typedef enum logic [1:0] {
      IDLE,
      ADVANCE,
      ROUTE
   } state_t;

   // First enabled channel strictly after cur, wrapping; cur if none other.
   function automatic logic [SEL_W-1:0] next_enabled(
      input logic [NCH-1:0]   mask,
      input logic [SEL_W-1:0] cur
   );
      logic [SEL_W-1:0] idx;
      logic             found;
      next_enabled = cur;
      found        = 1'b0;
      for (int i = 1; i <= NCH; i++) begin
         idx = cur + SEL_W'(i);
         if (!found && mask[idx]) begin
            next_enabled = idx;
            found        = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/demux_rr_sched_next.sv
// demux_rr_next: combinational priority rotator giving the
// next enabled channel after cur (cur itself if it is the only one).
module demux_rr_next
   import demux_sched_pkg::*;
(
   input  logic [NCH-1:0]   mask,
   input  logic [SEL_W-1:0] cur,
   output logic [SEL_W-1:0] nxt
);

   logic [2*NCH-1:0] dbl;
   logic [2*NCH-1:0] sh;
   logic [NCH-1:0]   rot;
   logic [SEL_W:0]   base;
   logic [SEL_W-1:0] ofs;
   logic             hit;

   // rot[j] is the channel j+1 places after cur; lowest set bit wins
   always_comb begin
      base = {1'b0, cur} + {{SEL_W{1'b0}}, 1'b1};
      dbl  = {mask, mask};
      sh   = dbl >> base;
      rot  = sh[NCH-1:0];
      ofs  = '0;
      hit  = 1'b0;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (rot[j]) begin
            ofs = SEL_W'(j);
            hit = 1'b1;
         end
      end
      nxt = hit ? (cur + ofs + SEL_W'(1)) : cur;
   end

endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: round-robin burst scheduler over 8 channels.
// Optional drained-beat counter beat_cnt under DEMUX_RR_SCHED_CNT_EN.
module demux_rr_sched
   import demux_sched_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int BURST  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic [NCH-1:0]    ch_en,
   output logic [DATA_W-1:0] out_data,
   output logic [NCH-1:0]    out_valid,
   input  logic [NCH-1:0]    out_ready,
   output logic [SEL_W-1:0]  sel,
   output logic              busy
`ifdef DEMUX_RR_SCHED_CNT_EN
   ,
   output logic [15:0]       beat_cnt
`endif
);

   localparam logic [7:0] CNT_LAST = 8'(BURST - 1);

   state_t           state;
   state_t           state_nx;
   logic [7:0]       cnt;
   logic [SEL_W-1:0] sel_nx;
   logic             full;
   logic             drain;
   logic             xfer;
   logic             burst_end;

   demux_rr_next u_next (
      .mask (ch_en),
      .cur  (sel),
      .nxt  (sel_nx)
   );

   assign full      = |out_valid;
   assign drain     = |(out_valid & out_ready);
   assign in_ready  = (state == ROUTE) & ch_en[sel] & (~full | drain);
   assign xfer      = in_valid & in_ready;
   assign burst_end = xfer & ((cnt == CNT_LAST) | in_last);
   assign busy      = (state == ROUTE) | full;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next state: serve the cursor until burst end or its enable drops
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (|ch_en) state_nx = ADVANCE;
         ADVANCE: state_nx = (|ch_en) ? ROUTE : IDLE;
         ROUTE:   if (!ch_en[sel] || burst_end) state_nx = ADVANCE;
         default: state_nx = IDLE;
      endcase
   end

   // Cursor moves only in ADVANCE; burst count restarts there
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel <= '0;
         cnt <= '0;
      end else if (state == ADVANCE) begin
         sel <= sel_nx;
         cnt <= '0;
      end else if (xfer) begin
         cnt <= cnt + 8'd1;
      end
   end

   // Output register: load on transfer, hold until the destination drains
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= '0;
      end else if (xfer) begin
         out_data  <= in_data;
         out_valid <= {{(NCH-1){1'b0}}, 1'b1} << sel;
      end else if (drain) begin
         out_valid <= '0;
      end
   end

`ifdef DEMUX_RR_SCHED_CNT_EN
   // Count beats drained to any channel, wrapping at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     beat_cnt <= '0;
      else if (drain) beat_cnt <= beat_cnt + 16'd1;
   end
`else
   // No drained-beat counter in this build
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
// tb_demux_rr_sched: cycle model of the scheduler rules plus
// directed scenarios with hand-computed delivery expectations.
module tb_demux_rr_sched;

   localparam int DW    = 8;
   localparam int BURST = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic          in_ready;
   logic [7:0]    ch_en = '0;
   logic [DW-1:0] out_data;
   logic [7:0]    out_valid;
   logic [7:0]    out_ready = '0;
   logic [2:0]    sel;
   logic          busy;
`ifdef DEMUX_RR_SCHED_CNT_EN
   logic [15:0]   beat_cnt;
`endif

   demux_rr_sched #(
      .DATA_W (DW),
      .BURST  (BURST)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .ch_en     (ch_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel       (sel),
      .busy      (busy)
`ifdef DEMUX_RR_SCHED_CNT_EN
      ,
      .beat_cnt  (beat_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state: mode 0 idle, 1 bubble (advance), 2 serving
   int            m_mode = 0;
   int            m_cur = 0;
   int            m_n = 0;
   bit            m_hv = 1'b0;
   int            m_hch = 0;
   logic [DW-1:0] m_hd = '0;
   int            m_drn = 0;
   int            cyc = 0;
   bit            acc_q = 1'b0;
   int            n_acc = 0;
   bit            last_en = 1'b0;
   logic [DW-1:0] last_tag = '0;
   logic [7:0]    seen_ov = '0;
   int            log_ch[$];
   int            log_d[$];
   int            acc_t[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   function automatic int nxt_en(input logic [7:0] m, input int cur);
      for (int i = 1; i <= 8; i++) begin
         int k;
         k = (cur + i) % 8;
         if (m[k]) return k;
      end
      return cur;
   endfunction

   function automatic int at(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic exp_log(input string t, input int i,
                          input int ch, input int d);
      chk({t, "_ch"}, 32'(at(log_ch, i)), 32'(ch));
      chk({t, "_data"}, 32'(at(log_d, i)), 32'(d));
   endtask

   task automatic clear_logs();
      log_ch.delete();
      log_d.delete();
      acc_t.delete();
      seen_ov = '0;
      n_acc = 0;
   endtask

   // one cycle of stimulus: advance data after an accepted beat
   task automatic tick();
      @(posedge clk);
      #1;
      if (acc_q) in_data = in_data + 1'b1;
      in_last = last_en && (in_data == last_tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      last_en = 1'b0;
      in_last = 1'b0;
      ch_en = '0;
      out_ready = '0;
      in_data = '0;
      tick();
      tick();
      clear_logs();
   endtask

   // compare process: check outputs, then step the model one cycle
   initial begin : cmp
      logic       exp_rdy;
      logic [7:0] exp_ov;
      bit         acc;
      bit         drn;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_mode = 0;
            m_cur = 0;
            m_n = 0;
            m_hv = 1'b0;
            m_drn = 0;
            cyc = 0;
            acc_q = 1'b0;
         end else begin
            exp_rdy = (m_mode == 2) && ch_en[m_cur]
                      && (!m_hv || out_ready[m_hch]);
            exp_ov = m_hv ? (8'd1 << m_hch) : 8'd0;
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("sel", 32'(sel), 32'(m_cur));
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (m_hv) chk("out_data", 32'(out_data), 32'(m_hd));
            chk("busy", 32'(busy), 32'((m_mode == 2) || m_hv));
`ifdef DEMUX_RR_SCHED_CNT_EN
            chk("beat_cnt", 32'(beat_cnt), 32'(m_drn & 16'hFFFF));
`endif
            seen_ov |= out_valid;
            acc = in_valid && in_ready;
            drn = m_hv && out_ready[m_hch];
            if (drn) begin
               log_ch.push_back(m_hch);
               log_d.push_back(int'(m_hd));
               m_drn++;
            end
            if (acc) begin
               acc_t.push_back(cyc);
               m_hv = 1'b1;
               m_hch = m_cur;
               m_hd = in_data;
               n_acc++;
            end else if (drn) begin
               m_hv = 1'b0;
            end
            case (m_mode)
               0: if (ch_en != 0) m_mode = 1;
               1: begin
                  m_cur = nxt_en(ch_en, m_cur);
                  m_n = 0;
                  m_mode = (ch_en != 0) ? 2 : 0;
               end
               default: begin
                  if (acc) begin
                     m_n++;
                     if (m_n == BURST || in_last) m_mode = 1;
                  end else if (!ch_en[m_cur]) begin
                     m_mode = 1;
                  end
               end
            endcase
            acc_q = acc;
            cyc++;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int waited;

      // A: reset state, full mask, continuous traffic
      do_reset();
      chk("A_rst_out_valid", 32'(out_valid), 32'h0);
      chk("A_rst_sel", 32'(sel), 32'h0);
      chk("A_rst_in_ready", 32'(in_ready), 32'h0);
      chk("A_rst_busy", 32'(busy), 32'h0);
      rst_n = 1'b1;
      ch_en = 8'hFF;
      out_ready = 8'hFF;
      in_valid = 1'b1;
      repeat (14) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      exp_log("A0", 0, 1, 0);
      exp_log("A3", 3, 1, 3);
      exp_log("A4", 4, 2, 4);
      exp_log("A7", 7, 2, 7);
      chk("A_first_accept", 32'(at(acc_t, 0)), 32'd2);
      chk("A_back_to_back", 32'(at(acc_t, 1) - at(acc_t, 0)), 32'd1);
      chk("A_bubble", 32'(at(acc_t, 4) - at(acc_t, 3)), 32'd2);

      // B: two enabled channels alternate 2,7,2,7
      do_reset();
      rst_n = 1'b1;
      ch_en = 8'b1000_0100;
      out_ready = 8'hFF;
      in_valid = 1'b1;
      repeat (24) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      exp_log("B0", 0, 2, 0);
      exp_log("B4", 4, 7, 4);
      exp_log("B8", 8, 2, 8);
      exp_log("B12", 12, 7, 12);
      chk("B_valid_mask", 32'(seen_ov), 32'h84);

      // C: in_last on the 2nd beat cuts the burst short
      do_reset();
      rst_n = 1'b1;
      ch_en = 8'hFF;
      out_ready = 8'hFF;
      last_en = 1'b1;
      last_tag = 8'd1;
      in_valid = 1'b1;
      repeat (12) tick();
      in_valid = 1'b0;
      last_en = 1'b0;
      repeat (3) tick();
      exp_log("C1", 1, 1, 1);
      exp_log("C2", 2, 2, 2);
      exp_log("C5", 5, 2, 5);
      exp_log("C6", 6, 3, 6);
      chk("C_last_bubble", 32'(at(acc_t, 2) - at(acc_t, 1)), 32'd2);
      chk("C_full_burst", 32'(at(acc_t, 5) - at(acc_t, 2)), 32'd3);

      // D: destination stalls 5 cycles, other channels ready
      do_reset();
      rst_n = 1'b1;
      ch_en = 8'hFF;
      out_ready = 8'hFF;
      in_valid = 1'b1;
      repeat (4) tick();
      out_ready = ~(8'd1 << m_hch);
      repeat (2) tick();
      chk("D_stall_data", 32'(out_data), 32'd1);
      chk("D_stall_ready", 32'(in_ready), 32'd0);
      repeat (3) tick();
      out_ready = 8'hFF;
      repeat (10) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      chk("D_no_loss", 32'(log_d.size()), 32'(n_acc));
      for (int i = 0; i < log_d.size(); i++)
         chk($sformatf("D_seq%0d", i), 32'(log_d[i]), 32'(i));

      // E: drop the served channel while its beat is held
      do_reset();
      rst_n = 1'b1;
      ch_en = 8'hFF;
      out_ready = 8'hFF;
      in_valid = 1'b1;
      waited = 0;
      while (n_acc < 2 && waited < 20) begin
         tick();
         waited++;
      end
      chk("E_wait_two", 32'(n_acc), 32'd2);
      out_ready = 8'h00;
      ch_en = 8'hFD;
      repeat (2) tick();
      chk("E_held_old_dst", 32'(out_valid), 32'h02);
      out_ready = 8'hFF;
      repeat (10) tick();
      in_valid = 1'b0;
      repeat (3) tick();
      exp_log("E1", 1, 1, 1);
      exp_log("E2", 2, 2, 2);
      exp_log("E3", 3, 2, 3);

      // F: asynchronous reset with a held beat, then empty mask
      do_reset();
      rst_n = 1'b1;
      ch_en = 8'hFF;
      out_ready = 8'hFF;
      in_valid = 1'b1;
      repeat (4) tick();
      out_ready = 8'h00;
      repeat (2) tick();
      chk("F_pre_held", 32'(out_valid), 32'h02);
      #1;
      rst_n = 1'b0;
      #1;
      chk("F_async_out_valid", 32'(out_valid), 32'h0);
      chk("F_async_sel", 32'(sel), 32'h0);
      chk("F_async_in_ready", 32'(in_ready), 32'h0);
      chk("F_async_busy", 32'(busy), 32'h0);
      clear_logs();
      ch_en = 8'h00;
      out_ready = 8'hFF;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (6) tick();
      chk("F_idle_in_ready", 32'(in_ready), 32'h0);
      chk("F_idle_out_valid", 32'(out_valid), 32'h0);
      chk("F_no_delivery", 32'(log_ch.size()), 32'h0);
      chk("F_idle_busy", 32'(busy), 32'h0);
      in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
